hazard_stall_controller: RTL and testbench

- Pipeline control block that drives the hold inputs of the PC register and the pipeline registers, plus flush/bubble controls.
- On the hold interface, the PC register consumes `pc_hold`: 1 means keep the current PC, 0 means load the new PC. This block produces that signal.
- Detects load-use hazards, taken-branch and jump redirects, and multi-cycle data-memory waits.
- Sits beside the ID/EX stages in the 5-stage MIPS pipeline.

---
 rtl/pipeline_ctrl_pkg.sv | 15 +
 rtl/hazard_stall_controller_mem_wait_timer.sv | 79 +++++++
 rtl/hazard_stall_controller.sv | 99 +++++++++
 tb/tb_hazard_stall_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks.
//   ST_RUN / ST_MEM_WAIT : state encoding of the data-memory wait FSM
//   REG_ZERO             : architectural zero register index (never a hazard)
//   REG_W_DEF            : default register-index width
package pipeline_ctrl_pkg;

    typedef logic state_t;

    localparam state_t     ST_RUN      = 1'b0;
    localparam state_t     ST_MEM_WAIT = 1'b1;

    localparam int         REG_W_DEF   = 5;
    localparam logic [4:0] REG_ZERO    = 5'd0;

endpackage

// File: rtl/hazard_stall_controller_mem_wait_timer.sv
// Data-memory wait timer: RUN/MEM_WAIT state machine plus down-counter.
// The freeze begins combinationally in the cycle mem_req is seen and lasts
// exactly MEM_WAIT_CYCLES cycles in total.
// Ports:
//   clk     in   pipeline clock, rising edge
//   reset   in   asynchronous active-low reset
//   mem_req in   load/store in MEM this cycle (single-cycle pulse)
//   frozen  out  full-pipeline freeze active
module mem_wait_timer
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_req,
    output logic frozen
);

    // The request cycle itself is the first frozen cycle, so the counter
    // only has to cover the remaining MEM_WAIT_CYCLES-1 cycles.
    localparam int   WAIT_W   = (MEM_WAIT_CYCLES > 2) ? $clog2(MEM_WAIT_CYCLES) : 1;
    localparam int   LOAD_VAL = (MEM_WAIT_CYCLES >= 2) ? MEM_WAIT_CYCLES - 1 : 0;
    localparam logic MULTI    = (MEM_WAIT_CYCLES >= 2);
    localparam logic ENABLED  = (MEM_WAIT_CYCLES >= 1);

    state_t              state_reg;
    state_t              state_next;
    logic [WAIT_W-1:0]   wait_cnt_reg;
    logic [WAIT_W-1:0]   wait_cnt_next;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (MULTI && mem_req) begin
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = WAIT_W'(LOAD_VAL);
                end
            end
            ST_MEM_WAIT: begin
                // mem_req is deliberately ignored here
                if (wait_cnt_reg == WAIT_W'(1)) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg - WAIT_W'(1);
                end
            end
            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Output logic (Mealy); forced low while reset is held
    always_comb begin
        frozen = 1'b0;
        if (reset) begin
            frozen = ((state_reg == ST_RUN) && mem_req && ENABLED) ||
                     (state_reg == ST_MEM_WAIT);
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Hazard / stall controller for the 5-stage pipeline. Drives PC and
// pipeline-register hold/flush controls for load-use hazards, taken
// branches, jumps and multi-cycle data-memory waits, and counts stalls.
// Priority: freeze > branch_taken > load-use > jump > none.
// Ports:
//   clk, reset                  clock / asynchronous active-low reset
//   id_rs, id_rt, id_uses_rt    source operands of the ID instruction
//   ex_mem_read, ex_rt          load in EX and its destination
//   branch_taken, id_jump       control-flow redirects
//   mem_req                     data-memory access starting in MEM
//   pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold
//                               pipeline controls (combinational, Mealy)
//   frozen                      full-pipeline freeze active
//   stall_count                 saturating count of cycles with pc_hold=1
module hazard_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = 2,
    parameter int CNT_W           = 16,
    parameter int REG_W           = REG_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             branch_taken,
    input  logic             id_jump,
    input  logic             mem_req,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_hold,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             frozen,
    output logic [CNT_W-1:0] stall_count
);

    logic             frozen_int;
    logic             load_use;
    logic [CNT_W-1:0] stall_count_reg;

    mem_wait_timer #(
        .MEM_WAIT_CYCLES (MEM_WAIT_CYCLES)
    ) u_mem_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .mem_req (mem_req),
        .frozen  (frozen_int)
    );

    // A load writing r0 produces no real value, so it can never stall.
    assign load_use = ex_mem_read &&
                      (ex_rt != REG_W'(REG_ZERO)) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        pc_hold    = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        idex_hold  = 1'b0;
        idex_flush = 1'b0;
        exmem_hold = 1'b0;
        if (reset) begin
            if (frozen_int) begin
                pc_hold    = 1'b1;
                ifid_hold  = 1'b1;
                idex_hold  = 1'b1;
                exmem_hold = 1'b1;
            end else if (branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_hold    = 1'b1;
                ifid_hold  = 1'b1;
                idex_flush = 1'b1;
            end else if (id_jump) begin
                // Squash the sequentially fetched instruction behind the jump.
                ifid_flush = 1'b1;
            end
        end
    end

    assign frozen = frozen_int;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_reg <= '0;
        end else if (pc_hold && (stall_count_reg != {CNT_W{1'b1}})) begin
            stall_count_reg <= stall_count_reg + CNT_W'(1);
        end
    end

    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

    localparam int N = 4;
    // Four configurations share one input stream.
    localparam int MWC_T [N] = '{2, 1, 0, 3};
    localparam int CW_T  [N] = '{16, 16, 16, 4};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0;
    logic       branch_taken = 1'b0, id_jump = 1'b0, mem_req = 1'b0;

    logic [6:0]  ctl_o [N];
    logic [15:0] cnt_o [N];

    int vectors = 0;
    int errors  = 0;

    // Reference model state: remaining frozen cycles after the current one,
    // and the stall count as a plain integer.
    int left_m [N];
    int cnt_m  [N];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        logic [CW_T[gi]-1:0] cnt_w;
        hazard_stall_controller #(
            .MEM_WAIT_CYCLES (MWC_T[gi]),
            .CNT_W           (CW_T[gi]),
            .REG_W           (5)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .id_rs        (id_rs),
            .id_rt        (id_rt),
            .id_uses_rt   (id_uses_rt),
            .ex_mem_read  (ex_mem_read),
            .ex_rt        (ex_rt),
            .branch_taken (branch_taken),
            .id_jump      (id_jump),
            .mem_req      (mem_req),
            .pc_hold      (ctl_o[gi][6]),
            .ifid_hold    (ctl_o[gi][5]),
            .ifid_flush   (ctl_o[gi][4]),
            .idex_hold    (ctl_o[gi][3]),
            .idex_flush   (ctl_o[gi][2]),
            .exmem_hold   (ctl_o[gi][1]),
            .frozen       (ctl_o[gi][0]),
            .stall_count  (cnt_w)
        );
        assign cnt_o[gi] = 16'(cnt_w);
    end

    function automatic bit model_frozen(int k);
        return (left_m[k] > 0) || (mem_req && MWC_T[k] >= 1);
    endfunction

    // Expected {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, frozen}
    function automatic logic [6:0] exp_ctl(int k);
        bit lu;
        lu = ex_mem_read && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
        if (!reset)                return 7'b0000000;
        else if (model_frozen(k))  return 7'b1101011;
        else if (branch_taken)     return 7'b0010100;
        else if (lu)               return 7'b1100100;
        else if (id_jump)          return 7'b0010000;
        else                       return 7'b0000000;
    endfunction

    task automatic check_all(string tag);
        logic [6:0]  e_ctl;
        logic [15:0] e_cnt;
        for (int k = 0; k < N; k++) begin
            e_ctl = exp_ctl(k);
            e_cnt = reset ? 16'(cnt_m[k]) : 16'd0;
            vectors++;
            assert (ctl_o[k] === e_ctl) else begin
                errors++;
                $error("FAIL %s ctl[%0d] observed=%b expected=%b", tag, k, ctl_o[k], e_ctl);
            end
            vectors++;
            assert (cnt_o[k] === e_cnt) else begin
                errors++;
                $error("FAIL %s cnt[%0d] observed=%0d expected=%0d", tag, k, cnt_o[k], e_cnt);
            end
        end
    endtask

    task automatic model_edge();
        int maxc;
        logic [6:0] e;
        for (int k = 0; k < N; k++) begin
            if (!reset) begin
                left_m[k] = 0;
                cnt_m[k]  = 0;
            end else begin
                e    = exp_ctl(k);
                maxc = (1 << CW_T[k]) - 1;
                if (e[6] && cnt_m[k] < maxc) cnt_m[k]++;
                if (left_m[k] > 0)                       left_m[k]--;
                else if (mem_req && MWC_T[k] >= 1)       left_m[k] = MWC_T[k] - 1;
            end
        end
    endtask

    // Inputs are already driven just after a rising edge; check mid-cycle,
    // then advance the model across the next rising edge.
    task automatic do_cycle(string tag);
        @(negedge clk);
        check_all(tag);
        $display("step %-10s rs=%0d rt=%0d ur=%0b rd=%0b ert=%0d br=%0b j=%0b mr=%0b ctl0=%b cnt0=%0d",
                 tag, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken,
                 id_jump, mem_req, ctl_o[0], cnt_o[0]);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                          input logic rd, input logic [4:0] ert, input logic br,
                          input logic j, input logic mr);
        id_rs = rs; id_rt = rt; id_uses_rt = ur; ex_mem_read = rd;
        ex_rt = ert; branch_taken = br; id_jump = j; mem_req = mr;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            left_m[k] = 0;
            cnt_m[k]  = 0;
        end
        #1;
        do_cycle("reset");
        do_cycle("reset");
        reset = 1'b1;

        // Load-use on rs
        set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0); do_cycle("lu_rs");
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); do_cycle("idle");
        // Register 0 guard, rt not used
        set_in(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); do_cycle("r0_guard");
        set_in(5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0); do_cycle("rt_unused");
        set_in(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0); do_cycle("lu_rt");
        // Branch beats load-use; load-use beats jump; lone jump
        set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0); do_cycle("br_over_lu");
        set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0); do_cycle("lu_over_j");
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); do_cycle("jump");
        // Memory freeze: branch during the second frozen cycle is ignored
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); do_cycle("mem_t");
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); do_cycle("mem_t1_br");
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); do_cycle("mem_t2");
        do_cycle("mem_t3");

        // Randomized traffic; small register range to provoke collisions
        for (int i = 0; i < 400; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
                   (mem_req == 1'b0) && ($urandom_range(0, 6) == 0));
            do_cycle("random");
        end

        // Reset asserted mid-freeze takes effect before the next edge
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); do_cycle("pre_rst");
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); do_cycle("rst_mem_t");
        set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        check_all("async_rst");
        $display("step async_rst ctl0=%b cnt0=%0d", ctl_o[0], cnt_o[0]);
        do_cycle("in_rst");
        reset = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); do_cycle("post_rst");

        // Saturation: 20 load-use cycles wrap nothing on the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
            do_cycle("saturate");
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); do_cycle("sat_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
